// File: rtl/memoria_instrucao_carregavel.sv
// Programmable instruction memory for the 16-bit MIPS datapath.
// Streaming load port with auto-increment pointer; registered byte-addressed fetch.
module memoria_instrucao_carregavel #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    fetch_req,
  output logic [DATA_WIDTH-1:0]   instrucao,
  output logic                    instr_valid,
  output logic                    desalinhado,
  input  logic                    carga_inicio,
  input  logic [DATA_WIDTH-1:0]   carga_dado,
  input  logic                    carga_valido,
  input  logic                    carga_fim,
  output logic                    carga_ocupado,
  output logic [$clog2(DEPTH):0]  carga_contagem,
  output logic                    carga_erro
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CHEIO = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMITE = (ADDR_WIDTH+1)'(2 * DEPTH);

  typedef enum logic {EXEC, LOAD} estado_t;

  estado_t               estado, estado_prox;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      mapa;
  logic [CW-1:0]         ponteiro;
  logic [IW-1:0]         idx;
  logic                  em_faixa;
  logic                  escreve;
  logic                  estoura;
  logic                  busca;

  assign idx      = pc[IW:1];
  assign em_faixa = {1'b0, pc} < LIMITE;

  // carga_inicio wins over every other request in the same cycle
  always_comb begin
    estado_prox = estado;
    escreve     = 1'b0;
    estoura     = 1'b0;
    busca       = 1'b0;
    priority case (1'b1)
      carga_inicio: estado_prox = LOAD;
      estado == LOAD: begin
        escreve = carga_valido && (ponteiro != CHEIO);
        estoura = carga_valido && (ponteiro == CHEIO);
        if (carga_fim) estado_prox = EXEC;
      end
      default: busca = fetch_req;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= EXEC;
      mapa       <= '0;
      ponteiro   <= '0;
      carga_erro <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (carga_inicio) begin
        mapa       <= '0;
        ponteiro   <= '0;
        carga_erro <= 1'b0;
      end else begin
        if (escreve) begin
          mapa[ponteiro[IW-1:0]] <= 1'b1;
          ponteiro               <= ponteiro + 1'b1;
        end
        if (estoura) carga_erro <= 1'b1;
      end
    end
  end

  // array itself is not reset; the bitmap gates every read
  always_ff @(posedge clock) begin
    if (escreve) mem[ponteiro[IW-1:0]] <= carga_dado;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrucao   <= '0;
      instr_valid <= 1'b0;
      desalinhado <= 1'b0;
    end else begin
      instr_valid <= busca;
      if (busca) begin
        instrucao   <= (em_faixa && mapa[idx]) ? mem[idx] : '0;
        desalinhado <= pc[0];
      end
    end
  end

  assign carga_ocupado  = (estado == LOAD);
  assign carga_contagem = ponteiro;

endmodule

// File: tb/tb_memoria_instrucao_carregavel.sv
// Scoreboard bench for memoria_instrucao_carregavel.
// Reference model keeps the loaded program as a queue of words.
module tb_memoria_instrucao_carregavel;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 64;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [AW-1:0]          pc;
  logic                   fetch_req;
  logic [DW-1:0]          instrucao;
  logic                   instr_valid;
  logic                   desalinhado;
  logic                   carga_inicio;
  logic [DW-1:0]          carga_dado;
  logic                   carga_valido;
  logic                   carga_fim;
  logic                   carga_ocupado;
  logic [$clog2(DEPTH):0] carga_contagem;
  logic                   carga_erro;

  memoria_instrucao_carregavel #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .pc(pc), .fetch_req(fetch_req),
    .instrucao(instrucao), .instr_valid(instr_valid),
    .desalinhado(desalinhado), .carga_inicio(carga_inicio),
    .carga_dado(carga_dado), .carga_valido(carga_valido),
    .carga_fim(carga_fim), .carga_ocupado(carga_ocupado),
    .carga_contagem(carga_contagem), .carga_erro(carga_erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] instr;
    logic          desal;
    int            due;
  } esperado_t;

  esperado_t     fila[$];
  logic [DW-1:0] prog[$];
  bit            m_load;
  bit            m_erro;
  logic [DW-1:0] m_last;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nome, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  always @(negedge clock) begin
    esperado_t e;
    if (instr_valid === 1'b1) begin
      if (fila.size() == 0) begin
        chk("spurious_instr_valid", 32'd1, 32'd0);
      end else begin
        e = fila.pop_front();
        chk("instrucao", 32'(instrucao), 32'(e.instr));
        chk("desalinhado", 32'(desalinhado), 32'(e.desal));
        chk("fetch_latency", cyc, e.due);
      end
    end else if (fila.size() > 0 && fila[0].due <= cyc) begin
      void'(fila.pop_front());
      chk("instr_valid_missing", 32'(instr_valid), 32'd1);
    end
  end

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] p);
    int w;
    w = int'(p) / 2;
    if (int'(p) < 2 * DEPTH && w < prog.size()) return prog[w];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic status();
    chk("carga_ocupado", 32'(carga_ocupado), 32'(m_load));
    chk("carga_contagem", 32'(carga_contagem), prog.size());
    chk("carga_erro", 32'(carga_erro), 32'(m_erro));
  endtask

  task automatic fetch(input logic [AW-1:0] p);
    pc        = p;
    fetch_req = 1'b1;
    if (!m_load) begin
      m_last = ref_word(p);
      fila.push_back('{instr: m_last, desal: p[0], due: cyc + 1});
    end
    tick();
    fetch_req = 1'b0;
    if (m_load) chk("hold_during_load", 32'(instrucao), 32'(m_last));
  endtask

  task automatic start_load(input bit with_fetch);
    carga_inicio = 1'b1;
    fetch_req    = with_fetch;
    pc           = '0;
    prog.delete();
    m_erro = 1'b0;
    m_load = 1'b1;
    tick();
    carga_inicio = 1'b0;
    fetch_req    = 1'b0;
    chk("ocupado_after_inicio", 32'(carga_ocupado), 32'd1);
    if (with_fetch) chk("hold_on_inicio", 32'(instrucao), 32'(m_last));
  endtask

  task automatic load_word(input logic [DW-1:0] d, input bit fim);
    carga_valido = 1'b1;
    carga_dado   = d;
    carga_fim    = fim;
    if (prog.size() < DEPTH) prog.push_back(d);
    else m_erro = 1'b1;
    if (fim) m_load = 1'b0;
    tick();
    carga_valido = 1'b0;
    carga_fim    = 1'b0;
  endtask

  task automatic end_load();
    carga_fim = 1'b1;
    m_load    = 1'b0;
    tick();
    carga_fim = 1'b0;
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    #2;
    chk("ocupado_async_reset", 32'(carga_ocupado), 32'd0);
    chk("instr_async_reset", 32'(instrucao), 32'd0);
    prog.delete();
    m_load = 1'b0;
    m_erro = 1'b0;
    m_last = '0;
    tick();
    reset = 1'b0;
    status();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit fechou;
    reset        = 1'b1;
    pc           = '0;
    fetch_req    = 1'b0;
    carga_inicio = 1'b0;
    carga_dado   = '0;
    carga_valido = 1'b0;
    carga_fim    = 1'b0;
    m_load       = 1'b0;
    m_erro       = 1'b0;
    m_last       = '0;
    idle(2);
    chk("reset_instrucao", 32'(instrucao), 32'd0);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    chk("reset_desalinhado", 32'(desalinhado), 32'd0);
    status();
    reset = 1'b0;

    fetch(16'd0); fetch(16'd2); fetch(16'd126);
    idle(2);

    start_load(1'b0);
    load_word(16'h6080, 1'b0);
    load_word(16'h6100, 1'b0);
    load_word(16'h2094, 1'b0);
    end_load();
    status();
    fetch(16'd4); fetch(16'd6);
    idle(1);

    start_load(1'b0);
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    load_word(16'hABCD, 1'b0);
    load_word(16'h3333, 1'b1);
    fetch(16'd6); fetch(16'd5); fetch(16'd4); fetch(16'd8);
    status();

    start_load(1'b0);
    for (int i = 0; i < 65; i++) load_word(DW'($urandom), 1'b0);
    status();
    end_load();
    status();
    fetch(16'd126); fetch(16'd128); fetch(16'd127); fetch(16'hFFFE);
    for (int i = 0; i < 40; i++) fetch(AW'($urandom_range(0, 140)));

    start_load(1'b0);
    fetch(16'd0); fetch(16'd2); fetch(16'd4);
    load_word(16'h0F0F, 1'b0);
    load_word(16'hF0F0, 1'b0);
    end_load();
    fetch(16'd0); fetch(16'd2); fetch(16'd4);

    start_load(1'b1);
    load_word(16'h5A5A, 1'b1);
    fetch(16'd0); fetch(16'd1);
    status();

    start_load(1'b0);
    load_word(16'h1234, 1'b0);
    load_word(16'h5678, 1'b0);
    hit_reset();
    fetch(16'd0); fetch(16'd2);
    status();

    start_load(1'b0);
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    load_word(16'hCCCC, 1'b0);
    start_load(1'b0);
    load_word(16'hDDDD, 1'b0);
    end_load();
    fetch(16'd0); fetch(16'd2); fetch(16'd4);
    status();

    for (int r = 0; r < 15; r++) begin
      start_load(1'b0);
      n = $urandom_range(0, 68);
      fechou = 1'b0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        fechou = (i == n - 1) && ($urandom_range(0, 1) == 1);
        load_word(DW'($urandom), fechou);
      end
      if (!fechou) end_load();
      status();
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        else fetch(AW'($urandom_range(0, 135)));
      end
    end

    idle(3);
    chk("scoreboard_drained", fila.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memoria_instrucao_carregavel.md
# memoria_instrucao_carregavel

Parametrised, programmable instruction memory for the 16-bit MIPS datapath, replacing the fixed, initial-block ROM as the instruction source. The program is loaded at run time through a streaming load port with an auto-incrementing write pointer. Fetches from the PC are registered, byte-addressed and range-checked. Words not written since reset or since the last load start read as NOP (all zeros).

## Interface
Parameters:
- DATA_WIDTH, 16, instruction word width
- ADDR_WIDTH, 16, PC width (byte address)
- DEPTH, 64, number of words; power of two, ≥ 2

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- pc  in  ADDR_WIDTH  byte address of the instruction to fetch
- fetch_req  in  1  fetch strobe
- instrucao  out  DATA_WIDTH  registered fetched word
- instr_valid  out  1  one-cycle pulse: instrucao updated this cycle
- desalinhado  out  1  registered with instrucao: pc[0] was 1
- carga_inicio  in  1  start (or restart) a program load
- carga_dado  in  DATA_WIDTH  word to write
- carga_valido  in  1  carga_dado is valid this cycle
- carga_fim  in  1  end the load
- carga_ocupado  out  1  high while in LOAD
- carga_contagem  out  clog2(DEPTH)+1  words written in the current/last load
- carga_erro  out  1  sticky: write attempted past DEPTH

## Operation
- State machine, two states: EXEC (fetch allowed) and LOAD (fetch blocked).
- Per-word valid bitmap (DEPTH bits). A word is readable only if its bit is set. Memory array contents are not reset; the bitmap is.
- Reset: state EXEC; bitmap all 0; pointer and carga_contagem 0; instrucao 0; instr_valid 0; desalinhado 0; carga_erro 0; carga_ocupado 0.
- carga_inicio, in any state: clear bitmap, pointer, and carga_erro, then enter LOAD.
  - Has priority over carga_valido, carga_fim and fetch_req in the same cycle; those are dropped.
- LOAD, carga_valido=1, pointer < DEPTH: write mem[pointer] = carga_dado, set its bitmap bit, pointer+1.
- LOAD, carga_valido=1, pointer = DEPTH: write dropped, carga_erro set, pointer held.
- LOAD, carga_fim=1: return to EXEC. A carga_valido write in the same cycle is still performed.
- carga_contagem = pointer; it holds its value after LOAD ends.
- EXEC fetch, when fetch_req=1, computes word index = pc[ADDR_WIDTH-1:1]. Next edge:
  - instrucao = mem[index] if pc < 2*DEPTH and bitmap[index]=1; otherwise 0.
  - desalinhado = pc[0].
  - instr_valid = 1.
- Misaligned pc: the low bit is ignored for indexing, and desalinhado flags it.
- Out-of-range pc (pc ≥ 2*DEPTH): instrucao = 0, no wrap-around.
- fetch_req=0, or state LOAD: instr_valid=0; instrucao and desalinhado hold.
- carga_ocupado = (state == LOAD).

## Timing
- Fetch latency: 1 cycle. A fetch_req at edge n gives instrucao and instr_valid=1 after edge n+1.
- Back-to-back fetches are accepted every cycle (throughput 1 word/cycle).
- Load write takes effect at the accepting edge.
- The first fetch is allowed in the cycle after the carga_fim edge (state EXEC). It sees every word written, including one written with carga_fim.
- carga_inicio to carga_ocupado=1: 1 edge. carga_fim to carga_ocupado=0: 1 edge.
- Reset mid-load: immediate, asynchronous. Returns to EXEC with the bitmap cleared, so all fetches return 0 until the next load.
- No combinational path from any input to any output.

## Test plan
- Reset then fetch pc=0, 2, 126 → instrucao=0x0000 each time, instr_valid pulses, desalinhado=0.
- Load 0x6080, 0x6100, 0x2094, then carga_fim; fetch pc=4 → 0x2094 one cycle later. Fetch pc=6 → 0x0000 (unwritten). carga_contagem=3.
- DEPTH=64: load 65 words → carga_erro=1, carga_contagem=64. Fetch pc=126 returns word 63. Fetch pc=128 → 0x0000.
- Fetch pc=5 after loading word 2 = 0xABCD → instrucao=0xABCD, desalinhado=1.
- fetch_req held during LOAD → instr_valid stays 0 and instrucao holds its previous value. carga_inicio together with fetch_req in EXEC → fetch dropped, carga_ocupado=1.
- Assert reset mid-load after 2 words, then fetch pc=0 → 0x0000, carga_ocupado=0. Restart with carga_inicio mid-load → earlier words read 0 until rewritten.
